// File: rtl/cbus_sram_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cbus_sram_responder_pkg
//  Description : CBus request/response typedefs and burst-length helper
//                shared by the CBus SRAM responder and its storage array.
//  Revision    : 1.0 - initial release
// ============================================================================
package cbus_sram_responder_pkg;

   // Burst length encoding: 1, 2, 4, 8 or 16 beats
   typedef enum logic [2:0] {
      MLEN1  = 3'd0,
      MLEN2  = 3'd1,
      MLEN4  = 3'd2,
      MLEN8  = 3'd3,
      MLEN16 = 3'd4
   } mlen_t;

   // Transfer size (carried on the bus, not used by word-wide targets)
   typedef enum logic [1:0] {
      MSIZE_B = 2'd0,
      MSIZE_H = 2'd1,
      MSIZE_W = 2'd2
   } msize_t;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      msize_t      size;
      logic [31:0] addr;
      logic [3:0]  strobe;
      logic [31:0] data;
      mlen_t       len;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;

   // Number of beats described by a burst-length code; unknown codes map to 1
   function automatic logic [4:0] mlen_beats(input mlen_t len);
      logic [4:0] beats;
      case (len)
         MLEN1:   beats = 5'd1;
         MLEN2:   beats = 5'd2;
         MLEN4:   beats = 5'd4;
         MLEN8:   beats = 5'd8;
         MLEN16:  beats = 5'd16;
         default: beats = 5'd1;
      endcase
      return beats;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cbus_sram_responder_array.sv
`default_nettype none
// ============================================================================
//  Module      : cbus_sram_array
//  Description : 2^DEPTH_LOG x 32 storage with one combinational read port
//                and one synchronous byte-strobed write port. Not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module cbus_sram_array
   import cbus_sram_responder_pkg::*;
#(
   parameter int DEPTH_LOG = 12
) (
   input  logic                 clk,
   input  logic                 i_we,
   input  logic [3:0]           i_strb,
   input  logic [DEPTH_LOG-1:0] i_addr,
   input  logic [31:0]          i_wdata,
   output logic [31:0]          o_rdata
);

   // One independent byte-wide array per lane keeps each lane single-driven
   for (genvar i = 0; i < 4; i++) begin : g_lane
      logic [7:0] r_mem [2**DEPTH_LOG];

      // Lane write: only when the beat writes and this lane's strobe is set
      always_ff @(posedge clk) begin
         if (i_we && i_strb[i]) begin
            r_mem[i_addr] <= i_wdata[8*i +: 8];
         end
      end

      assign o_rdata[8*i +: 8] = r_mem[i_addr];
   end

endmodule
`default_nettype wire

// File: rtl/cbus_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : cbus_sram_responder
//  Description : CBus target backed by a word-wide SRAM. Accepts one burst
//                at a time, waits LATENCY cycles, streams one beat per cycle,
//                then inserts a one-cycle gap before the next request.
//  Revision    : 1.0 - initial release
// ============================================================================
module cbus_sram_responder
   import cbus_sram_responder_pkg::*;
#(
   parameter int DEPTH_LOG = 12,
   parameter int LATENCY   = 2
) (
   input  logic       clk,
   input  logic       resetn,
   input  cbus_req_t  req,
   output cbus_resp_t resp
);

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_WAIT  = 2'd1;
   localparam logic [1:0] c_ST_BURST = 2'd2;
   localparam logic [1:0] c_ST_GAP   = 2'd3;

   // Wait counter start value; the counter is not used when LATENCY is 0
   localparam logic [3:0] c_LAT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   logic [1:0]           r_state;
   logic [1:0]           w_state_nxt;
   logic [3:0]           r_lat_cnt;
   logic [3:0]           r_beats_left;
   logic [DEPTH_LOG-1:0] r_idx;
   logic                 r_is_write;
   logic                 w_last_beat;
   logic                 w_we;
   logic [31:0]          w_rdata;

   // Transfer size and sub-word address bits carry no meaning for this target
   logic w_unused;
   assign w_unused = &{1'b0, req.size, req.addr};

   assign w_last_beat = (r_beats_left == 4'd0);

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state: a dropped valid in WAIT or BURST abandons the burst at once
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (req.valid) begin
               w_state_nxt = (LATENCY == 0) ? c_ST_BURST : c_ST_WAIT;
            end
         end
         c_ST_WAIT: begin
            if (!req.valid) begin
               w_state_nxt = c_ST_IDLE;
            end else if (r_lat_cnt == 4'd0) begin
               w_state_nxt = c_ST_BURST;
            end
         end
         c_ST_BURST: begin
            if (!req.valid) begin
               w_state_nxt = c_ST_IDLE;
            end else if (w_last_beat) begin
               w_state_nxt = c_ST_GAP;
            end
         end
         c_ST_GAP: begin
            w_state_nxt = c_ST_IDLE;
         end
         default: begin
            w_state_nxt = c_ST_IDLE;
         end
      endcase
   end

   // Response and write strobe: everything is quiet outside BURST
   always_comb begin
      resp  = '0;
      w_we  = 1'b0;
      if (r_state == c_ST_BURST) begin
         resp.ready = 1'b1;
         resp.last  = w_last_beat;
         resp.data  = r_is_write ? 32'd0 : w_rdata;
         w_we       = r_is_write & req.valid;
      end
   end

   // Burst bookkeeping: capture the request at acceptance, then count beats
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_lat_cnt    <= 4'd0;
         r_beats_left <= 4'd0;
         r_idx        <= '0;
         r_is_write   <= 1'b0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (req.valid) begin
                  r_idx        <= req.addr[DEPTH_LOG+1:2];
                  r_is_write   <= req.is_write;
                  r_lat_cnt    <= c_LAT_INIT;
                  r_beats_left <= 4'(mlen_beats(req.len) - 5'd1);
               end
            end
            c_ST_WAIT: begin
               if (r_lat_cnt != 4'd0) begin
                  r_lat_cnt <= r_lat_cnt - 4'd1;
               end
            end
            c_ST_BURST: begin
               if (req.valid) begin
                  r_idx        <= r_idx + 1'b1;
                  r_beats_left <= r_beats_left - 4'd1;
               end
            end
            default: begin
               r_lat_cnt <= 4'd0;
            end
         endcase
      end
   end

   cbus_sram_array #(
      .DEPTH_LOG (DEPTH_LOG)
   ) u_array (
      .clk     (clk),
      .i_we    (w_we),
      .i_strb  (req.strobe),
      .i_addr  (r_idx),
      .i_wdata (req.data),
      .o_rdata (w_rdata)
   );

endmodule
`default_nettype wire
